// File: rtl/refresh_issue_ctrl_if.sv
// refresh_issue_ctrl_if: handshake bundle between the refresh scheduler, the dummy-refresh filter and the DRAM command scheduler
//   master (refresh_issue_ctrl): drives to_refresh, ref_req, ref_active, urgent, pending, overflow, dummy_cnt, auto_cnt
//   slave  (filter / DRAM scheduler): drives dref, dram_busy, ref_gnt
interface refresh_issue_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             to_refresh;
    logic             dref;
    logic             dram_busy;
    logic             ref_req;
    logic             ref_gnt;
    logic             ref_active;
    logic             urgent;
    logic [3:0]       pending;
    logic             overflow;
    logic [CNT_W-1:0] dummy_cnt;
    logic [CNT_W-1:0] auto_cnt;
    modport master (
        output to_refresh, ref_req, ref_active, urgent, pending, overflow, dummy_cnt, auto_cnt,
        input  dref, dram_busy, ref_gnt
    );
    modport slave (
        input  to_refresh, ref_req, ref_active, urgent, pending, overflow, dummy_cnt, auto_cnt,
        output dref, dram_busy, ref_gnt
    );
endinterface

// File: rtl/refresh_issue_ctrl.sv
// refresh_issue_ctrl: refresh interval timer, owed-refresh queue and req/gnt issue FSM around the dummy-refresh filter
//   clk, rst_n        clock, async active-low reset
//   bus (master)      to_refresh pulse out / dref verdict in; ref_req/ref_gnt handshake, dram_busy,
//                     ref_active, urgent, pending, overflow, dummy_cnt, auto_cnt
//   REF_STATS_EN      when defined, dummy_cnt/auto_cnt count skipped and issued refreshes; otherwise tied to 0
module refresh_issue_ctrl #(
    parameter int TREFI_CYC    = 3900,
    parameter int TRFC_CYC     = 280,
    parameter int MAX_POSTPONE = 8,
    parameter int CNT_W        = 32
) (
    input logic                  clk,
    input logic                  rst_n,
    refresh_issue_ctrl_if.master bus
);
    localparam int CW = $clog2(TREFI_CYC);
    localparam int WW = $clog2(TRFC_CYC + 1);
    // RFC covers the tRFC window minus the grant cycle, counting down to 0
    localparam logic [WW-1:0] W_LOAD = WW'(TRFC_CYC > 1 ? TRFC_CYC - 2 : 0);
    localparam logic [3:0] PMAX = 4'(MAX_POSTPONE);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RFC  = 2'd2;

    logic [CW-1:0] cnt;
    logic          dec_v;
    logic [3:0]    pend;
    logic [3:0]    pend_nx;
    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [WW-1:0] wcnt;
    logic          ovf;
    logic          sat;
    logic          auto_v;
    logic          grant;
    logic          inc;

    assign bus.to_refresh = cnt == CW'(TREFI_CYC - 1);
    assign sat            = pend == PMAX;
    assign auto_v         = dec_v && !bus.dref;
    assign grant          = state == S_REQ && bus.ref_gnt;
    // a saturated auto verdict still lands when a grant frees a slot in the same cycle
    assign inc            = auto_v && (!sat || grant);
    assign pend_nx        = pend + 4'(inc) - 4'(grant);

    // IDLE looks at pend_nx so a fresh auto verdict requests on the very next edge
    always_comb
        state_nx = state == S_IDLE ? ((pend_nx != 4'd0 && (!bus.dram_busy || pend_nx == PMAX)) ? S_REQ : S_IDLE)
                 : state == S_REQ  ? (bus.ref_gnt ? (TRFC_CYC > 1 ? S_RFC : S_IDLE) : S_REQ)
                 : (wcnt == '0 ? S_IDLE : S_RFC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            dec_v <= 1'b0;
            pend  <= '0;
            state <= S_IDLE;
            wcnt  <= '0;
            ovf   <= 1'b0;
        end else begin
            cnt   <= bus.to_refresh ? '0 : cnt + 1'b1;
            dec_v <= bus.to_refresh;
            pend  <= pend_nx;
            state <= state_nx;
            wcnt  <= grant ? W_LOAD : wcnt - WW'(wcnt != '0);
            ovf   <= ovf | (auto_v && sat);
        end
    end

    assign bus.ref_req    = state == S_REQ;
    assign bus.ref_active = grant || state == S_RFC;
    assign bus.urgent     = sat;
    assign bus.pending    = pend;
    assign bus.overflow   = ovf;

`ifdef REF_STATS_EN
    logic [CNT_W-1:0] dummy_q;
    logic [CNT_W-1:0] auto_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dummy_q <= '0;
            auto_q  <= '0;
        end else begin
            dummy_q <= dummy_q + CNT_W'(dec_v && bus.dref);
            auto_q  <= auto_q + CNT_W'(grant);
        end
    end
    assign bus.dummy_cnt = dummy_q;
    assign bus.auto_cnt  = auto_q;
`else
    assign bus.dummy_cnt = {CNT_W{1'b0}};
    assign bus.auto_cnt  = {CNT_W{1'b0}};
`endif

    // a grant is only possible with at least one owed refresh
    assert property (@(posedge clk) disable iff (!rst_n) !(grant && pend == 4'd0));
endmodule

// File: tb/tb_refresh_issue_ctrl.sv
// tb_refresh_issue_ctrl: directed bench with a cycle-level behavioural model of the refresh scheduler
module tb_refresh_issue_ctrl;
    localparam int TREFI = 16;
    localparam int TRFC  = 4;
    localparam int MAXP  = 2;
`ifdef REF_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    refresh_issue_ctrl_if #(.CNT_W(32)) bus();
    refresh_issue_ctrl #(
        .TREFI_CYC(TREFI), .TRFC_CYC(TRFC), .MAX_POSTPONE(MAXP), .CNT_W(32)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int t       = 0;
    int owed, act_end, n_dummy, n_auto;
    bit req_out, ovf_m, dec, g;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, t, got, exp);
        end
    endtask

    // Model: owed refreshes as a plain count, an outstanding-request flag and the
    // last cycle of the current tRFC window; t counts cycles since reset release.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            owed = 0; act_end = -1; n_dummy = 0; n_auto = 0; req_out = 0; ovf_m = 0; t = 0;
            chk("rst_outs", 32'({bus.to_refresh, bus.ref_req, bus.ref_active, bus.urgent, bus.pending, bus.overflow}), 32'd0);
            chk("rst_cnts", bus.dummy_cnt | bus.auto_cnt, 32'd0);
        end else begin
            chk("m_to_refresh", 32'(bus.to_refresh), 32'(t % TREFI == TREFI - 1));
            chk("m_ref_req", 32'(bus.ref_req), 32'(req_out));
            chk("m_ref_active", 32'(bus.ref_active), 32'((req_out && bus.ref_gnt) || t <= act_end));
            chk("m_urgent", 32'(bus.urgent), 32'(owed == MAXP));
            chk("m_pending", 32'(bus.pending), 32'(owed));
            chk("m_overflow", 32'(bus.overflow), 32'(ovf_m));
            chk("m_dummy_cnt", bus.dummy_cnt, STATS ? 32'(n_dummy) : 32'd0);
            chk("m_auto_cnt", bus.auto_cnt, STATS ? 32'(n_auto) : 32'd0);
            dec = t > 0 && t % TREFI == 0;
            g   = req_out && bus.ref_gnt;
            if (dec && bus.dref) n_dummy++;
            if (g) n_auto++;
            if (dec && !bus.dref) begin
                if (owed == MAXP) ovf_m = 1;
                if (owed < MAXP || g) owed++;
            end
            if (g) begin
                owed--;
                req_out = 0;
                act_end = t + TRFC - 1;
            end else if (!req_out && t > act_end && owed > 0 && (!bus.dram_busy || owed == MAXP))
                req_out = 1;
            t++;
        end
    end

    task automatic start(input bit b, input bit gn, input bit d);
        rst_n = 1'b0;
        bus.dram_busy = b;
        bus.ref_gnt   = gn;
        bus.dref      = d;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic goto(input int n);
        while (t < n) @(posedge clk);
        #2;
    endtask

    initial begin
        #60000;
        $display("FAIL watchdog cycle=%0d", t);
        $fatal(1);
    end

    initial begin
        // 1: free-running with immediate grants
        start(0, 1, 0);
        goto(14); chk("t1_pulse14", 32'(bus.to_refresh), 32'd0);
        goto(15); chk("t1_pulse15", 32'(bus.to_refresh), 32'd1);
        goto(16); chk("t1_req16", 32'(bus.ref_req), 32'd0);
        goto(17); chk("t1_req17", 32'(bus.ref_req), 32'd1);
        chk("t1_act17", 32'(bus.ref_active), 32'd1);
        chk("t1_pend17", 32'(bus.pending), 32'd1);
        goto(20); chk("t1_act20", 32'(bus.ref_active), 32'd1);
        goto(21); chk("t1_act21", 32'(bus.ref_active), 32'd0);
        chk("t1_pend21", 32'(bus.pending), 32'd0);
        goto(31); chk("t1_pulse31", 32'(bus.to_refresh), 32'd1);
        goto(33); chk("t1_req33", 32'(bus.ref_req), 32'd1);
        goto(40);
        // 2: every verdict dummy
        start(0, 1, 1);
        goto(66); chk("t2_pend", 32'(bus.pending), 32'd0);
        chk("t2_dummy", bus.dummy_cnt, STATS ? 32'd4 : 32'd0);
        chk("t2_auto", bus.auto_cnt, 32'd0);
        // 3: busy postpones until urgent
        start(1, 1, 0);
        goto(17); chk("t3_pend17", 32'(bus.pending), 32'd1);
        chk("t3_req17", 32'(bus.ref_req), 32'd0);
        goto(33); chk("t3_pend33", 32'(bus.pending), 32'd2);
        chk("t3_urg33", 32'(bus.urgent), 32'd1);
        chk("t3_req33", 32'(bus.ref_req), 32'd1);
        goto(34); chk("t3_pend34", 32'(bus.pending), 32'd1);
        chk("t3_urg34", 32'(bus.urgent), 32'd0);
        // 4: no grants, saturation and sticky overflow
        start(1, 0, 0);
        goto(48); chk("t4_ovf48", 32'(bus.overflow), 32'd0);
        goto(49); chk("t4_ovf49", 32'(bus.overflow), 32'd1);
        chk("t4_pend49", 32'(bus.pending), 32'd2);
        chk("t4_req49", 32'(bus.ref_req), 32'd1);
        bus.ref_gnt = 1'b1;
        goto(51); chk("t4_pend51", 32'(bus.pending), 32'd1);
        goto(60); chk("t4_ovf60", 32'(bus.overflow), 32'd1);
        // 5: grant in the same cycle as an auto verdict
        start(0, 0, 0);
        goto(17); chk("t5_req17", 32'(bus.ref_req), 32'd1);
        goto(31); chk("t5_pend31", 32'(bus.pending), 32'd1);
        goto(32); bus.ref_gnt = 1'b1;
        goto(33); bus.ref_gnt = 1'b0;
        chk("t5_pend33", 32'(bus.pending), 32'd1);
        chk("t5_req33", 32'(bus.ref_req), 32'd0);
        chk("t5_act33", 32'(bus.ref_active), 32'd1);
        goto(40);
        // 6: async reset in the tRFC window
        start(0, 1, 0);
        goto(18); chk("t6_act18", 32'(bus.ref_active), 32'd1);
        rst_n = 1'b0;
        #1 chk("t6_async", 32'({bus.to_refresh, bus.ref_req, bus.ref_active, bus.urgent, bus.pending, bus.overflow}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        goto(14); chk("t6_pulse14", 32'(bus.to_refresh), 32'd0);
        goto(15); chk("t6_pulse15", 32'(bus.to_refresh), 32'd1);
        // 7: mixed deterministic traffic, checked by the model
        start(0, 1, 0);
        for (int c = 0; c < 240; c++) begin
            goto(c);
            bus.dref      = ((c / 16) % 3) == 1;
            bus.dram_busy = (c % 7) < 3;
            bus.ref_gnt   = (c % 5) != 0;
        end
        goto(250);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
